// File: rtl/hex_display_if.sv
// hex_display_if: value/load inputs and scanned digit outputs of the hex display scanner
interface hex_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    blank_zeros;
    logic [3:0]              digit_nibble;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    digit_blank;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output value_in, load, blank_zeros,
        input  digit_nibble, digit_sel, digit_blank, frame_start, pending
    );

    modport slave (
        input  value_in, load, blank_zeros,
        output digit_nibble, digit_sel, digit_blank, frame_start, pending
    );
endinterface

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed 7-segment hex scanner with frame-aligned double buffering
module hex_display_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input logic          clk,
    input logic          rst,
    hex_display_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         capture_q, capture_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  blank_q, blank_d;
    logic                  frame_q, frame_d;
    logic                  tick, boundary, commit, zero_acc;
    logic [NUM_DIGITS-1:0] zero_from, one_hot;

    // Next state: shadow_d already holds a same-tick commit so digit 0 shows the new value at once
    always_comb begin
        tick      = presc_q == PW'(REFRESH_DIV - 1);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        boundary  = tick && idx_q == '0;
        commit    = boundary && (pending_q || bus.load);
        shadow_d  = commit ? (bus.load ? bus.value_in : capture_q) : shadow_q;
        capture_d = bus.load ? bus.value_in : capture_q;
        pending_d = commit ? 1'b0 : (bus.load || pending_q);
        idx_d     = !tick ? idx_q : (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1);
        zero_acc  = 1'b1;
        zero_from = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_acc     = zero_acc && shadow_d[4*k +: 4] == 4'd0;
            zero_from[k] = zero_acc;
        end
        one_hot        = '0;
        one_hot[idx_q] = 1'b1;
        sel_d    = tick ? ~one_hot : sel_q;
        nibble_d = tick ? shadow_d[{idx_q, 2'b00} +: 4] : nibble_q;
        blank_d  = tick ? (bus.blank_zeros && idx_q != '0 && zero_from[idx_q]) : blank_q;
        frame_d  = boundary;
    end

    // State and registered display outputs; reset discards any pending capture
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            capture_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            sel_q     <= '1;
            nibble_q  <= '0;
            blank_q   <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            capture_q <= capture_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            nibble_q  <= nibble_d;
            blank_q   <= blank_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.digit_sel    = sel_q;
    assign bus.digit_nibble = nibble_q;
    assign bus.digit_blank  = blank_q;
    assign bus.frame_start  = frame_q;
    assign bus.pending      = pending_q;
endmodule
